// File: rtl/reg_range_reader.sv
// reg_range_reader
//
// Sequential read initiator for a 32-entry register file. A start command
// latches an inclusive index range [addr_lo, addr_hi]. The range is then
// walked two registers per beat through read ports Ra/Rb. Each beat is
// streamed out under a valid/ready handshake.
//
// Ports
//   Clock, Reset_n          : clock; synchronous active-low reset
//   start, addr_lo, addr_hi : command strobe and inclusive range (IDLE only)
//   Ra, Rb                  : register-file read addresses
//   busA, busB              : register-file read data for Ra / Rb
//   out_valid, out_ready    : beat handshake
//   out_addr                : index of out_dataA
//   out_dataA, out_dataB    : register values (out_dataB is 0 when out_two=0)
//   out_two                 : out_dataB carries a real register
//   busy                    : command in progress
//   done, err               : one-cycle end-of-command pulse; err = bad range
module reg_range_reader #(
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [4:0]        addr_lo,
    input  logic [4:0]        addr_hi,
    output logic [4:0]        Ra,
    output logic [4:0]        Rb,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_addr,
    output logic [DATA_W-1:0] out_dataA,
    output logic [DATA_W-1:0] out_dataB,
    output logic              out_two,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t            state_q, state_d;
    logic [4:0]        cur_q, cur_d;
    logic [4:0]        hi_q, hi_d;
    logic [4:0]        ra_q, ra_d;
    logic [4:0]        rb_q, rb_d;
    logic              valid_q, valid_d;
    logic [4:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              two_q, two_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Next pair base, widened to 6 bits so that hi=31 ends the walk
    // instead of wrapping back to index 0 or 1.
    logic [5:0] nxt;
    assign nxt = {1'b0, cur_q} + 6'd2;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        hi_d     = hi_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        two_d    = two_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (addr_lo <= addr_hi) begin
                        hi_d    = addr_hi;
                        cur_d   = addr_lo;
                        ra_d    = addr_lo;
                        // A single-register tail points Rb at Ra rather
                        // than past the end of the range.
                        rb_d    = (addr_lo < addr_hi) ? addr_lo + 5'd1 : addr_lo;
                        state_d = WAIT;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Ra/Rb were driven on the previous edge; the buses have
                // settled by now.
                addr_d   = cur_q;
                data_a_d = busA;
                two_d    = (cur_q < hi_q);
                data_b_d = (cur_q < hi_q) ? busB : '0;
                valid_d  = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (nxt > {1'b0, hi_q}) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cur_d   = nxt[4:0];
                        ra_d    = nxt[4:0];
                        rb_d    = (nxt < {1'b0, hi_q}) ? nxt[4:0] + 5'd1 : nxt[4:0];
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            hi_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            two_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            hi_q     <= hi_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            two_q    <= two_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Ra        = ra_q;
    assign Rb        = rb_q;
    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_dataA = data_a_q;
    assign out_dataB = data_b_q;
    assign out_two   = two_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_range_reader.sv
// Testbench for reg_range_reader: a register-file model drives busA/busB,
// and expected beats are queued when a command is issued. They are popped and
// compared at each handshake.
module tb_reg_range_reader;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        start;
    logic [4:0]  addr_lo, addr_hi;
    logic [4:0]  Ra, Rb;
    logic [31:0] busA, busB;
    logic        out_valid, out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_dataA, out_dataB;
    logic        out_two, busy, done, err;

    always #5 Clock = ~Clock;

    logic [31:0] rf [32];
    assign busA = rf[Ra];
    assign busB = rf[Rb];

    reg_range_reader #(.DATA_W(32)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .start(start),
        .addr_lo(addr_lo), .addr_hi(addr_hi), .Ra(Ra), .Rb(Rb),
        .busA(busA), .busB(busB), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_dataA(out_dataA), .out_dataB(out_dataB),
        .out_two(out_two), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] a;
        logic [31:0] b;
        logic        two;
    } beat_t;

    beat_t       q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          hs_count = 0;
    logic        done_seen;
    logic        last_err;
    logic [4:0]  ra_hist [64];
    logic [4:0]  rb_hist [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then step past the rising edge.
    task automatic tick();
        logic  hs;
        beat_t e;
        @(negedge Clock);
        hs = out_valid && out_ready;
        if (hs) begin
            chk("beat_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_addr",  32'(out_addr), 32'(e.addr));
                chk("out_dataA", out_dataA, e.a);
                chk("out_dataB", out_dataB, e.b);
                chk("out_two",   32'(out_two), 32'(e.two));
            end
        end
        if (done) begin
            done_seen = 1'b1;
            last_err  = err;
        end
        @(posedge Clock);
        #1;
        if (hs) begin
            hs_count++;
            ra_hist[hs_count] = Ra;
            rb_hist[hs_count] = Rb;
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] da, input logic [31:0] db,
                        input logic two);
        beat_t e;
        e.addr = a; e.a = da; e.b = db; e.two = two;
        q.push_back(e);
    endtask

    task automatic start_cmd(input logic [4:0] lo, input logic [4:0] hi);
        addr_lo = lo;
        addr_hi = hi;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Run to the done pulse; exp_cyc>0 checks edges from start to last handshake.
    task automatic finish_cmd(input string tag, input int nbeats, input int exp_cyc);
        int cyc    = 0;
        int base   = hs_count;
        int hs_cyc = -1;
        done_seen  = 1'b0;
        last_err   = 1'b1;
        while (!done_seen && cyc < 30) begin
            tick();
            cyc++;
            if (hs_count - base == nbeats && hs_cyc < 0) hs_cyc = cyc;
        end
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({tag, "_err"}, 32'(last_err), 32'd0);
        chk({tag, "_beats"}, 32'(hs_count - base), 32'(nbeats));
        chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
        if (exp_cyc > 0) chk({tag, "_latency"}, 32'(hs_cyc), 32'(exp_cyc));
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_Ra"}, 32'(Ra), 32'd0);
        chk({tag, "_Rb"}, 32'(Rb), 32'd0);
        chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        chk({tag, "_out_dataA"}, out_dataA, 32'd0);
        chk({tag, "_out_dataB"}, out_dataB, 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_two"}, 32'(out_two), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + 32'(i);
        rf[1] = 32'd11; rf[2] = 32'd22; rf[3] = 32'd33; rf[4] = 32'd44;
        rf[31] = 32'hDEADBEEF;

        Reset_n = 1'b0; start = 1'b0; addr_lo = '0; addr_hi = '0; out_ready = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        Reset_n = 1'b1;
        tick();

        // Even range, full throughput
        push(5'd1, 32'd11, 32'd22, 1'b1);
        push(5'd3, 32'd33, 32'd44, 1'b1);
        start_cmd(5'd1, 5'd4);
        chk("t1_Ra", 32'(Ra), 32'd1);
        chk("t1_Rb", 32'(Rb), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_valid_e0", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid_e1", 32'(out_valid), 32'd1);
        q.delete();
        push(5'd1, 32'd11, 32'd22, 1'b1);
        push(5'd3, 32'd33, 32'd44, 1'b1);
        finish_cmd("t1", 2, 3);

        // Odd range: second read has Rb pinned to the last index
        push(5'd1, 32'd11, 32'd22, 1'b1);
        push(5'd3, 32'd33, 32'd0, 1'b0);
        base = hs_count;
        start_cmd(5'd1, 5'd3);
        finish_cmd("t2", 2, 4);
        chk("t2_Ra2", 32'(ra_hist[base + 1]), 32'd3);
        chk("t2_Rb2", 32'(rb_hist[base + 1]), 32'd3);

        // Top boundary, single register
        push(5'd31, 32'hDEADBEEF, 32'd0, 1'b0);
        start_cmd(5'd31, 5'd31);
        chk("t3_Ra", 32'(Ra), 32'd31);
        chk("t3_Rb", 32'(Rb), 32'd31);
        finish_cmd("t3", 1, 2);
        tick();
        tick();
        chk("t3_no_second_beat", 32'(out_valid), 32'd0);

        // Rejected range
        start_cmd(5'd5, 5'd2);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_Ra", 32'(Ra), 32'd31);
        chk("t4_Rb", 32'(Rb), 32'd31);
        tick();
        chk("t4_done_clr", 32'(done), 32'd0);
        chk("t4_err_clr", 32'(err), 32'd0);
        chk("t4_valid2", 32'(out_valid), 32'd0);
        chk("t4_busy2", 32'(busy), 32'd0);

        // Backpressure with an ignored start during the hold
        out_ready = 1'b0;
        push(5'd1, 32'd11, 32'd22, 1'b1);
        push(5'd3, 32'd33, 32'd44, 1'b1);
        start_cmd(5'd1, 5'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_addr", 32'(out_addr), 32'd1);
            chk("t5_hold_dataA", out_dataA, 32'd11);
            chk("t5_hold_dataB", out_dataB, 32'd22);
            chk("t5_hold_busy", 32'(busy), 32'd1);
            if (i == 1) begin
                addr_lo = 5'd5;
                addr_hi = 5'd9;
                start   = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        finish_cmd("t5", 2, 0);

        // Reset in the middle of a handshake
        out_ready = 1'b0;
        push(5'd1, 32'd11, 32'd22, 1'b1);
        push(5'd3, 32'd33, 32'd44, 1'b1);
        start_cmd(5'd1, 5'd4);
        tick();
        chk("t6_in_send", 32'(out_valid), 32'd1);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        chk_zero("t6_reset");
        q.delete();
        out_ready = 1'b1;
        push(5'd2, 32'd22, 32'd33, 1'b1);
        start_cmd(5'd2, 5'd3);
        chk("t6_Ra", 32'(Ra), 32'd2);
        chk("t6_Rb", 32'(Rb), 32'd3);
        finish_cmd("t6", 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
